get_stream_checker: RTL
=======================

# get_stream_checker

Synthesizable sink that drains a Bluespec-style Get interface (`EN_get`/`RDY_get`/`get`) and checks the returned words against a programmed arithmetic sequence. It is the hardware consumer counterpart to the put-side producer used around `mkHardware`: it plugs onto any module's Get port. It optionally throttles acceptance with an LFSR to exercise back-pressure. It reports word count, a running sum, first-mismatch details and completion.

## Interface
- `DATA_W`, 32, data word width
- `CNT_W`, 8, width of word counter and count configuration
- `LFSR_SEED`, 16'hACE1, reset value of the 16-bit throttle LFSR (must be nonzero)

- `CLK`  in  1  clock, all state on rising edge
- `RST_N`  in  1  reset; one clock, reset asynchronous and active-low
- `start`  in  1  single-cycle request to arm a new check run
- `cfg_count`  in  CNT_W  number of words to consume
- `cfg_base`  in  DATA_W  expected value of first word
- `cfg_stride`  in  DATA_W  increment between expected words
- `cfg_throttle`  in  1  1 = accept only when LFSR bit 0 is 1
- `RDY_get`  in  1  source has a word available
- `get`  in  DATA_W  source data, valid while `RDY_get`=1
- `EN_get`  out  1  consume strobe
- `busy`  out  1  in RUN
- `done`  out  1  run complete, held until next start
- `error`  out  1  sticky: at least one mismatch this run
- `rx_count`  out  CNT_W  words consumed this run
- `bad_idx`  out  CNT_W  index of first mismatching word
- `bad_data`  out  DATA_W  value of first mismatching word
- `checksum`  out  DATA_W  sum of consumed words mod 2^DATA_W

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE or DONE, with `start`=1:
  - latch `cfg_*` into shadow registers
  - expected ← `cfg_base`
  - clear `rx_count`, `checksum`, `error`, `bad_idx` and `bad_data`
  - if `cfg_count`=0, go to DONE; otherwise go to RUN
- `cfg_*` changes after the start cycle have no effect on the run in progress.
- `start` in RUN is ignored.
- `EN_get` = (state==RUN) & `RDY_get` & (!throttle_shadow | lfsr[0]). The term is combinational, and `EN_get` never asserts while `RDY_get`=0.
- Fire = `EN_get` & `RDY_get`. On a fire cycle the following happen at the next edge:
  - `checksum` += `get`
  - `rx_count` += 1
  - expected += stride, wrapping mod 2^DATA_W
  - if `get` ≠ expected and `error`=0: `error`←1, `bad_idx`←`rx_count`, `bad_data`←`get`
  - later mismatches do not overwrite the captured values
  - if `rx_count`==count_shadow−1, go to DONE
- LFSR is Galois, polynomial x^16+x^14+x^13+x^11+1. It shifts every cycle in RUN and holds otherwise.
- `busy` = (state==RUN). `done` = (state==DONE).

## Timing
- Reset values:
  - `EN_get`, `busy`, `done`, `error` = 0
  - `rx_count`, `bad_idx`, `bad_data`, `checksum` = 0
  - LFSR = `LFSR_SEED`
  - state = IDLE
- An asynchronous reset assertion mid-run forces `EN_get` low immediately and abandons the run with no partial `done`.
- `EN_get` may first assert the cycle after the `start` edge.
- With throttle off, throughput is one word per cycle when `RDY_get` stays high.
- `done` rises the cycle after the final fire. `rx_count` equals count_shadow on that cycle, and `EN_get` is 0 from that cycle on.
- Run with `cfg_count`=0: `done` rises one cycle after `start` and no fire occurs.
- `error`, `bad_*` and `checksum` remain valid and stable in DONE until the next `start`.

## Test plan
- Basic run:
  - Stimulus: base=0, stride=4, count=6, throttle=0; source supplies 0,4,8,12,16,20 with `RDY_get`=1.
  - Required: 6 consecutive fires, `done`=1, `rx_count`=6, `checksum`=60, `error`=0.
- Mismatch capture:
  - Stimulus: same config; source supplies 0,4,9,12,17,20.
  - Required: `error`=1, `bad_idx`=2, `bad_data`=9, `checksum`=62, `rx_count`=6.
- Throttle:
  - Stimulus: throttle=1; `RDY_get` toggles randomly; correct data.
  - Required: `EN_get` is never high when `RDY_get`=0; `EN_get` is only high when lfsr[0]=1; the run completes with `error`=0 and `checksum`=60.
- Wrap-around:
  - Stimulus: base=32'hFFFFFFF8, stride=4, count=4; source supplies FFFFFFF8, FFFFFFFC, 0, 4.
  - Required: `error`=0, `checksum`=32'hFFFFFFF8.
- Zero count and start-in-RUN:
  - Stimulus: count=0, then `start`.
  - Required: `done` the next cycle and `EN_get` never asserted.
  - Stimulus: `start` pulsed mid-run.
  - Required: no effect; `rx_count` continues.
- Reset mid-run:
  - Stimulus: drop `RST_N` after 3 words.
  - Required: `EN_get`=0 immediately; all outputs at reset values; a fresh `start` then completes a full 6-word run correctly.

Source files
------------

// File: rtl/get_stream_checker.sv
// Drains a Get-style source (EN_get/RDY_get/get) and checks the returned words against
// an arithmetic sequence, optionally throttling acceptance with a Galois LFSR.
module get_stream_checker #(
    parameter int          DATA_W    = 32,
    parameter int          CNT_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [DATA_W-1:0] cfg_base,
    input  logic [DATA_W-1:0] cfg_stride,
    input  logic              cfg_throttle,
    input  logic              RDY_get,
    input  logic [DATA_W-1:0] get,
    output logic              EN_get,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  bad_idx,
    output logic [DATA_W-1:0] bad_data,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [DATA_W-1:0]   stride_q,   stride_d;
    logic                throttle_q, throttle_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]    rx_count_q, rx_count_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                error_q,    error_d;
    logic [CNT_W-1:0]    bad_idx_q,  bad_idx_d;
    logic [DATA_W-1:0]   bad_data_q, bad_data_d;
    logic [15:0]         lfsr_q,     lfsr_d;
    logic                fire;

    // Combinational so the source sees the strobe in the same cycle it offers data.
    assign EN_get   = (state_q == RUN) & RDY_get & (~throttle_q | lfsr_q[0]);
    assign fire     = EN_get & RDY_get;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign error    = error_q;
    assign rx_count = rx_count_q;
    assign bad_idx  = bad_idx_q;
    assign bad_data = bad_data_q;
    assign checksum = checksum_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        stride_d   = stride_q;
        throttle_d = throttle_q;
        expected_d = expected_q;
        rx_count_d = rx_count_q;
        checksum_d = checksum_q;
        error_d    = error_q;
        bad_idx_d  = bad_idx_q;
        bad_data_d = bad_data_q;
        lfsr_d     = lfsr_q;

        if (state_q == RUN) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d    = cfg_count;
                    stride_d   = cfg_stride;
                    throttle_d = cfg_throttle;
                    expected_d = cfg_base;
                    rx_count_d = '0;
                    checksum_d = '0;
                    error_d    = 1'b0;
                    bad_idx_d  = '0;
                    bad_data_d = '0;
                    state_d    = (cfg_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    checksum_d = checksum_q + get;
                    rx_count_d = rx_count_q + CNT_ONE;
                    expected_d = expected_q + stride_q;
                    // Only the first mismatch of a run is recorded.
                    if ((get != expected_q) && !error_q) begin
                        error_d    = 1'b1;
                        bad_idx_d  = rx_count_q;
                        bad_data_d = get;
                    end
                    if (rx_count_q == (count_q - CNT_ONE)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            count_q    <= '0;
            stride_q   <= '0;
            throttle_q <= 1'b0;
            expected_q <= '0;
            rx_count_q <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
            bad_idx_q  <= '0;
            bad_data_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            stride_q   <= stride_d;
            throttle_q <= throttle_d;
            expected_q <= expected_d;
            rx_count_q <= rx_count_d;
            checksum_q <= checksum_d;
            error_q    <= error_d;
            bad_idx_q  <= bad_idx_d;
            bad_data_q <= bad_data_d;
            lfsr_q     <= lfsr_d;
        end
    end

endmodule
